reg_bank: RTL and testbench

//  32 x 32-bit general-purpose register file of the multicycle MIPS core; the write-side

---
 rtl/mips_pkg.sv | 17 +
 rtl/reg_bank_chk.sv | 15 +
 rtl/reg_read_port.sv | 43 ++++
 rtl/reg_bank.sv | 77 +++++++
 tb/tb_reg_bank.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS core: architectural register indices,
// the stack-pointer reset base and the destination-register (EntEnd) select codes.
package mips_pkg;

  localparam logic [4:0]  REG_ZERO         = 5'd0;
  localparam logic [4:0]  REG_SP           = 5'd29;
  localparam logic [4:0]  REG_RA           = 5'd31;
  localparam logic [31:0] SP_RESET_DEFAULT = 32'd227;

  typedef enum logic [1:0] {
    ENT_END_RT = 2'b00,
    ENT_END_RD = 2'b01,
    ENT_END_RA = 2'b10,
    ENT_END_SP = 2'b11
  } ent_end_sel_e;

endpackage : mips_pkg

// File: rtl/reg_bank_chk.sv
// Protocol checker for reg_bank: an enabled write must carry a known index.
module reg_bank_chk #(
  parameter int ADDR_W = 5
) (
  input logic              clk,
  input logic              reset,
  input logic              reg_write,
  input logic [ADDR_W-1:0] write_reg
);

  a_write_idx_known : assert property (
    @(posedge clk) disable iff (reset) reg_write |-> !$isunknown(write_reg)
  );

endmodule : reg_bank_chk

// File: rtl/reg_read_port.sv
// One asynchronous read port of the register file: index decode, optional
// same-cycle write forwarding, and the hardwired-zero mux for index 0.
module reg_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 0
) (
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] regs_i [1:(2**ADDR_W)-1],
  output logic [DATA_W-1:0] rd_data_o
);

  logic fwd_hit_s;

  // Forward only a write that will really land this edge (not suppressed by reset).
  always_comb begin
    fwd_hit_s = 1'b0;
    if (BYPASS != 0) begin
      fwd_hit_s = wr_en_i && !reset_i && (wr_addr_i == rd_addr_i);
    end else begin
      fwd_hit_s = 1'b0;
    end
  end

  // Output mux: zero register, forwarded data, or stored contents.
  always_comb begin
    rd_data_o = {DATA_W{1'b0}};
    if (rd_addr_i == {ADDR_W{1'b0}}) begin
      rd_data_o = {DATA_W{1'b0}};
    end else if (fwd_hit_s) begin
      rd_data_o = wr_data_i;
    end else begin
      rd_data_o = regs_i[rd_addr_i];
    end
  end

endmodule : reg_read_port

// File: rtl/reg_bank.sv
// 32 x 32 general-purpose register file: two combinational read ports, one
// synchronous write port, $zero hardwired, $sp reset to the stack base.
module reg_bank
  import mips_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_DEFAULT,
  parameter int                BYPASS   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int NREG = 2 ** ADDR_W;

  // Register 0 has no storage; the read ports mux it to zero.
  logic [DATA_W-1:0] regs_q [1:NREG-1];
  logic [DATA_W-1:0] regs_d [1:NREG-1];

  // Next-state: a single write per cycle, index 0 silently dropped.
  always_comb begin
    regs_d = regs_q;
    if (reg_write && (write_reg != {ADDR_W{1'b0}})) begin
      regs_d[write_reg] = write_data;
    end else begin
      regs_d = regs_q;
    end
  end

  // Storage update; reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : {DATA_W{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd_port1 (
    .reset_i   (reset),
    .wr_en_i   (reg_write),
    .wr_addr_i (write_reg),
    .wr_data_i (write_data),
    .rd_addr_i (read_reg1),
    .regs_i    (regs_q),
    .rd_data_o (read_data1)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd_port2 (
    .reset_i   (reset),
    .wr_en_i   (reg_write),
    .wr_addr_i (write_reg),
    .wr_data_i (write_data),
    .rd_addr_i (read_reg2),
    .regs_i    (regs_q),
    .rd_data_o (read_data2)
  );

endmodule : reg_bank

// File: tb/tb_reg_bank.sv
// Directed test of reg_bank: one BYPASS=0 and one BYPASS=1 instance share all inputs.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] rd1_nb, rd2_nb, rd1_bp, rd2_bp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_bank #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .reg_write(reg_write),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data),
    .read_data1(rd1_nb), .read_data2(rd2_nb)
  );

  reg_bank #(.BYPASS(1)) dut_bp (
    .clk(clk), .reset(reset), .reg_write(reg_write),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data),
    .read_data1(rd1_bp), .read_data2(rd2_bp)
  );

  reg_bank_chk #(.ADDR_W(5)) u_chk (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg)
  );

  task automatic edge_then_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    @(negedge clk);
    reset = 1'b1; reg_write = 1'b0;
    edge_then_settle();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      #1;
      exp = (i == 29) ? 32'd227 : 32'd0;
      n_checks++;
      if (rd1_nb !== exp) begin
        n_fail++;
        $display("FAIL reset_rd1[%0d]: got %h expected %h", i, rd1_nb, exp);
      end
      exp = ((31 - i) == 29) ? 32'd227 : 32'd0;
      n_checks++;
      if (rd2_nb !== exp) begin
        n_fail++;
        $display("FAIL reset_rd2[%0d]: got %h expected %h", 31 - i, rd2_nb, exp);
      end
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd8; write_data = 32'hDEADBEEF;
    read_reg1 = 5'd8; read_reg2 = 5'd8;
    #1;
    n_checks++;
    if (rd1_nb !== 32'h0) begin
      n_fail++;
      $display("FAIL write_same_cycle: got %h expected %h", rd1_nb, 32'h0);
    end
    edge_then_settle();
    reg_write = 1'b0;
    #1;
    n_checks++;
    if (rd1_nb !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_next_cycle: got %h expected %h", rd1_nb, 32'hDEADBEEF);
    end
    n_checks++;
    if (rd2_nb !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_both_ports: got %h expected %h", rd2_nb, 32'hDEADBEEF);
    end
  endtask

  task automatic test_zero_and_hold();
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h1234;
    read_reg1 = 5'd0; read_reg2 = 5'd8;
    edge_then_settle();
    reg_write = 1'b0;
    #1;
    n_checks++;
    if (rd1_nb !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_reg: got %h expected %h", rd1_nb, 32'h0);
    end
    n_checks++;
    if (rd1_bp !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_reg_bp: got %h expected %h", rd1_bp, 32'h0);
    end
    n_checks++;
    if (rd2_nb !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL zero_write_side_effect: got %h expected %h", rd2_nb, 32'hDEADBEEF);
    end
    // reg_write=0 with a live index and data must not store
    write_reg = 5'd8; write_data = 32'h0BAD0BAD;
    edge_then_settle();
    n_checks++;
    if (rd2_nb !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL no_write_hold: got %h expected %h", rd2_nb, 32'hDEADBEEF);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    reset = 1'b1; reg_write = 1'b1; write_reg = 5'd29; write_data = 32'h55;
    read_reg1 = 5'd29; read_reg2 = 5'd8;
    edge_then_settle();
    reset = 1'b0; reg_write = 1'b0;
    #1;
    n_checks++;
    if (rd1_nb !== 32'd227) begin
      n_fail++;
      $display("FAIL reset_prio_sp: got %h expected %h", rd1_nb, 32'd227);
    end
    n_checks++;
    if (rd2_nb !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_prio_clear: got %h expected %h", rd2_nb, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    read_reg1 = 5'd31; read_reg2 = 5'd29;
    reg_write = 1'b1; write_reg = 5'd31; write_data = 32'hCAFE;
    edge_then_settle();
    write_reg = 5'd29;
    #1;
    n_checks++;
    if (rd1_nb !== 32'hCAFE) begin
      n_fail++;
      $display("FAIL b2b_ra: got %h expected %h", rd1_nb, 32'hCAFE);
    end
    n_checks++;
    if (rd2_nb !== 32'd227) begin
      n_fail++;
      $display("FAIL b2b_sp_before: got %h expected %h", rd2_nb, 32'd227);
    end
    edge_then_settle();
    reg_write = 1'b0;
    #1;
    n_checks++;
    if (rd2_nb !== 32'hCAFE) begin
      n_fail++;
      $display("FAIL b2b_sp_after: got %h expected %h", rd2_nb, 32'hCAFE);
    end
    n_checks++;
    if (rd1_nb !== 32'hCAFE) begin
      n_fail++;
      $display("FAIL b2b_ra_hold: got %h expected %h", rd1_nb, 32'hCAFE);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd17; write_data = 32'hA5A5;
    read_reg1 = 5'd31; read_reg2 = 5'd17;
    #1;
    n_checks++;
    if (rd2_bp !== 32'hA5A5) begin
      n_fail++;
      $display("FAIL bypass_fwd: got %h expected %h", rd2_bp, 32'hA5A5);
    end
    n_checks++;
    if (rd2_nb !== 32'h0) begin
      n_fail++;
      $display("FAIL nobypass_old: got %h expected %h", rd2_nb, 32'h0);
    end
    n_checks++;
    if (rd1_bp !== 32'hCAFE) begin
      n_fail++;
      $display("FAIL bypass_other_port: got %h expected %h", rd1_bp, 32'hCAFE);
    end
    edge_then_settle();
    reg_write = 1'b0; write_data = 32'hFFFF;
    #1;
    n_checks++;
    if (rd2_nb !== 32'hA5A5) begin
      n_fail++;
      $display("FAIL nobypass_new: got %h expected %h", rd2_nb, 32'hA5A5);
    end
    n_checks++;
    if (rd2_bp !== 32'hA5A5) begin
      n_fail++;
      $display("FAIL bypass_idle: got %h expected %h", rd2_bp, 32'hA5A5);
    end
    // Forwarding must not apply to index 0
    reg_write = 1'b1; write_reg = 5'd0; read_reg2 = 5'd0;
    #1;
    n_checks++;
    if (rd2_bp !== 32'h0) begin
      n_fail++;
      $display("FAIL bypass_zero: got %h expected %h", rd2_bp, 32'h0);
    end
    // Forwarding must not apply while reset suppresses the write
    reset = 1'b1; write_reg = 5'd17; read_reg2 = 5'd17;
    #1;
    n_checks++;
    if (rd2_bp !== 32'hA5A5) begin
      n_fail++;
      $display("FAIL bypass_reset: got %h expected %h", rd2_bp, 32'hA5A5);
    end
    edge_then_settle();
    reset = 1'b0; reg_write = 1'b0;
    #1;
    n_checks++;
    if (rd2_bp !== 32'h0) begin
      n_fail++;
      $display("FAIL bypass_after_reset: got %h expected %h", rd2_bp, 32'h0);
    end
  endtask

  initial begin
    reset = 1'b0; reg_write = 1'b0;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    write_reg = 5'd0; write_data = 32'h0;
    test_reset();
    test_write();
    test_zero_and_hold();
    test_reset_priority();
    test_back_to_back();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_bank
